// File: rtl/mux_unstriping_pkg.sv
// Shared constants for the two-lane unstriping merge: lane encodings,
// default FIFO geometry and the reset values of the registered outputs.
package mux_unstriping_pkg;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int PTR_W              = $clog2(DEFAULT_FIFO_DEPTH);

  localparam logic DATA_OUT_RST_BIT = 1'b0;
  localparam logic LANE_SEL_RST     = LANE0;

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane skew FIFO: registered count, extra-MSB pointers, sticky overflow
// when a word arrives while full and nothing leaves on the same edge.
module unstripe_lane_fifo
  import mux_unstriping_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_2f) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_unstriping.sv
// Merges two striped lanes back into one stream, strictly alternating
// lane 0, lane 1, ... and stalling on the expected lane rather than skipping.
module mux_unstriping
  import mux_unstriping_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in_0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  valid_in_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  overflow_0,
  output logic                  overflow_1,
  output logic                  lane_sel
);

  logic [DATA_WIDTH-1:0] dout0;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  empty0;
  logic                  empty1;
  logic                  full0;
  logic                  full1;
  logic                  pop0;
  logic                  pop1;

  assign pop0 = (lane_sel == LANE0) && !empty0;
  assign pop1 = (lane_sel == LANE1) && !empty1;

  unstripe_lane_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo0 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .push     (valid_in_0),
    .din      (data_in0),
    .pop      (pop0),
    .dout     (dout0),
    .empty    (empty0),
    .full     (full0),
    .overflow (overflow_0)
  );

  unstripe_lane_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo1 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .push     (valid_in_1),
    .din      (data_in1),
    .pop      (pop1),
    .dout     (dout1),
    .empty    (empty1),
    .full     (full1),
    .overflow (overflow_1)
  );

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_out  <= {DATA_WIDTH{DATA_OUT_RST_BIT}};
      valid_out <= 1'b0;
      lane_sel  <= LANE_SEL_RST;
    end else if (pop0) begin
      data_out  <= dout0;
      valid_out <= 1'b1;
      lane_sel  <= LANE1;
    end else if (pop1) begin
      data_out  <= dout1;
      valid_out <= 1'b1;
      lane_sel  <= LANE0;
    end else begin
      data_out  <= {DATA_WIDTH{DATA_OUT_RST_BIT}};
      valid_out <= 1'b0;
    end
  end

  // Fullness is only needed inside the FIFOs; kept visible for debug probes.
  logic unused_full;
  assign unused_full = full0 ^ full1;

endmodule

// File: tb/tb_mux_unstriping.sv
// Directed bench for mux_unstriping: each step drives one clk_2f edge and
// checks the registered outputs 1 time unit after that edge.
module tb_mux_unstriping;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] data_in0;
  logic        valid_in_0;
  logic [31:0] data_in1;
  logic        valid_in_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        overflow_0;
  logic        overflow_1;
  logic        lane_sel;

  int total = 0;
  int bad   = 0;

  mux_unstriping #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in0   (data_in0),
    .valid_in_0 (valid_in_0),
    .data_in1   (data_in1),
    .valid_in_1 (valid_in_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1),
    .lane_sel   (lane_sel)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic applyStimulus(input logic rst, input logic v0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] d1);
    reset      = rst;
    valid_in_0 = v0;
    data_in0   = d0;
    valid_in_1 = v1;
    data_in1   = d1;
    @(posedge clk_2f);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [31:0] ed,
                             input logic el);
    total++;
    assert (valid_out === ev) else begin
      bad++;
      $error("[TB] FAIL %s valid_out got=%0b exp=%0b", tag, valid_out, ev);
    end
    total++;
    assert (data_out === ed) else begin
      bad++;
      $error("[TB] FAIL %s data_out got=%h exp=%h", tag, data_out, ed);
    end
    total++;
    assert (lane_sel === el) else begin
      bad++;
      $error("[TB] FAIL %s lane_sel got=%0b exp=%0b", tag, lane_sel, el);
    end
  endtask

  task automatic checkFlags(input string tag, input logic e0, input logic e1);
    total++;
    assert (overflow_0 === e0) else begin
      bad++;
      $error("[TB] FAIL %s overflow_0 got=%0b exp=%0b", tag, overflow_0, e0);
    end
    total++;
    assert (overflow_1 === e1) else begin
      bad++;
      $error("[TB] FAIL %s overflow_1 got=%0b exp=%0b", tag, overflow_1, e1);
    end
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput(tag, 1'b0, 32'h0, 1'b0);
    checkFlags(tag, 1'b0, 1'b0);
  endtask

  task automatic idleStep(input string tag, input logic ev, input logic [31:0] ed,
                          input logic el);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput(tag, ev, ed, el);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    doReset("reset");

    // basic alternation
    applyStimulus(1'b0, 1'b1, 32'hA0, 1'b0, 32'h0);
    checkOutput("basic_s1", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hB0);
    checkOutput("basic_s2", 1'b1, 32'hA0, 1'b1);
    idleStep("basic_s3", 1'b1, 32'hB0, 1'b0);
    idleStep("basic_s4", 1'b0, 32'h0, 1'b0);

    // skew: lane 1 arrives early and must wait for lane 0
    doReset("skew_rst");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h11);
    checkOutput("skew_s1", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
    checkOutput("skew_s2", 1'b0, 32'h0, 1'b0);
    idleStep("skew_s3", 1'b0, 32'h0, 1'b0);
    idleStep("skew_s4", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h01, 1'b0, 32'h0);
    checkOutput("skew_s5", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h02, 1'b0, 32'h0);
    checkOutput("skew_s6", 1'b1, 32'h01, 1'b1);
    idleStep("skew_s7", 1'b1, 32'h11, 1'b0);
    idleStep("skew_s8", 1'b1, 32'h02, 1'b1);
    idleStep("skew_s9", 1'b1, 32'h22, 1'b0);
    idleStep("skew_s10", 1'b0, 32'h0, 1'b0);

    // overflow on lane 1: fifth word is dropped
    doReset("ovf_rst");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'(i));
      if (i == 4) checkFlags("ovf_after4", 1'b0, 1'b0);
    end
    checkFlags("ovf_after5", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hA, 1'b0, 32'h0);
    checkOutput("ovf_o0", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hB, 1'b0, 32'h0);
    checkOutput("ovf_o1", 1'b1, 32'hA, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
    checkOutput("ovf_o2", 1'b1, 32'h1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hD, 1'b0, 32'h0);
    checkOutput("ovf_o3", 1'b1, 32'hB, 1'b1);
    idleStep("ovf_o4", 1'b1, 32'h2, 1'b0);
    idleStep("ovf_o5", 1'b1, 32'hC, 1'b1);
    idleStep("ovf_o6", 1'b1, 32'h3, 1'b0);
    idleStep("ovf_o7", 1'b1, 32'hD, 1'b1);
    idleStep("ovf_o8", 1'b1, 32'h4, 1'b0);
    idleStep("ovf_o9", 1'b0, 32'h0, 1'b0);
    checkFlags("ovf_sticky", 1'b0, 1'b1);

    // full FIFO 0 accepts a word on an edge where it is also popped
    doReset("fp_rst");
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    checkOutput("fp_s1", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h11, 1'b0, 32'h0);
    checkOutput("fp_s2", 1'b1, 32'h10, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h12, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h13, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h14, 1'b0, 32'h0);
    checkOutput("fp_s5", 1'b0, 32'h0, 1'b1);
    checkFlags("fp_full", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    checkOutput("fp_s6", 1'b0, 32'h0, 1'b1);
    idleStep("fp_s7", 1'b1, 32'h20, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h15, 1'b0, 32'h0);
    checkOutput("fp_s8", 1'b1, 32'h11, 1'b1);
    checkFlags("fp_pushpop", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h21);
    checkOutput("fp_s9", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
    checkOutput("fp_s10", 1'b1, 32'h21, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h23);
    checkOutput("fp_s11", 1'b1, 32'h12, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h24);
    checkOutput("fp_s12", 1'b1, 32'h22, 1'b0);
    idleStep("fp_s13", 1'b1, 32'h13, 1'b1);
    idleStep("fp_s14", 1'b1, 32'h23, 1'b0);
    idleStep("fp_s15", 1'b1, 32'h14, 1'b1);
    idleStep("fp_s16", 1'b1, 32'h24, 1'b0);
    idleStep("fp_s17", 1'b1, 32'h15, 1'b1);
    idleStep("fp_s18", 1'b0, 32'h0, 1'b1);
    checkFlags("fp_end", 1'b0, 1'b0);

    // mid-stream reset discards buffered lane 1 words
    doReset("mid_rst0");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h31);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h32);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h33);
    checkOutput("mid_buffered", 1'b0, 32'h0, 1'b0);
    doReset("mid_rst1");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h77);
    checkOutput("mid_s1", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h66, 1'b0, 32'h0);
    checkOutput("mid_s2", 1'b0, 32'h0, 1'b0);
    idleStep("mid_s3", 1'b1, 32'h66, 1'b1);
    idleStep("mid_s4", 1'b1, 32'h77, 1'b0);
    idleStep("mid_s5", 1'b0, 32'h0, 1'b0);

    // back-to-back 32-word stream, one word per cycle
    doReset("b2b_rst");
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) begin
        if (i % 2 == 0) applyStimulus(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0, 32'h0);
        else            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i));
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      if (i == 0) checkOutput("b2b_first", 1'b0, 32'h0, 1'b0);
      else        checkOutput($sformatf("b2b_w%0d", i - 1), 1'b1, 32'h1000 + 32'(i - 1),
                              ((i % 2) == 1) ? 1'b1 : 1'b0);
    end
    idleStep("b2b_tail", 1'b0, 32'h0, 1'b0);
    checkFlags("b2b_flags", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_unstriping.md
Name: mux_unstriping

Overview:
- Receive-side counterpart of demux_striping. It merges two striped lanes back into one 32-bit stream at clk_2f.
- demux_striping sends valid words alternately to lane 0 and lane 1, starting with lane 0. This block restores the original order: lane 0, lane 1, lane 0, and so on.
- A small FIFO on each lane absorbs inter-lane skew. It sits after the lane receivers, ahead of the consumer.

Parameters:
- DATA_WIDTH, 32, word width of the lanes and the output.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.

Ports:
- clk_2f  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in0  input  DATA_WIDTH  lane 0 word.
- valid_in_0  input  1  lane 0 word qualifier.
- data_in1  input  DATA_WIDTH  lane 1 word.
- valid_in_1  input  1  lane 1 word qualifier.
- data_out  output  DATA_WIDTH  merged word, registered.
- valid_out  output  1  data_out qualifier, registered.
- overflow_0  output  1  sticky flag: a lane 0 word was dropped.
- overflow_1  output  1  sticky flag: a lane 1 word was dropped.
- lane_sel  output  1  lane expected next (0 or 1), registered; for debug.

Behaviour:
- Reset is sampled on clk_2f.
  - While reset=1: data_out=0, valid_out=0, overflow_0/1=0, lane_sel=0.
  - Both FIFOs are emptied and their pointers cleared.
  - Reset asserted mid-stream discards all buffered words. The next word after release must come from lane 0.
- Lane FIFO writes:
  - An edge with valid_in_x=1 writes data_inx, unless FIFO x is full and is not being popped on that same edge.
  - Invalid input words are never stored.
- Merge rule, evaluated each edge:
  - If FIFO[lane_sel] is non-empty (count as of before this edge): pop its head into data_out, set valid_out=1, and toggle lane_sel.
  - Otherwise: valid_out=0, data_out=0, lane_sel holds.
  - The block never skips a lane. A word waiting on the other lane stays until the expected lane delivers.
- Latency: a word written at edge N onto the expected lane, with that FIFO empty, appears on data_out after edge N+1. There is no bypass path.
- Throughput: one word per cycle, sustained while the two lanes alternate.
- Simultaneous push and pop on one FIFO:
  - Allowed; the count is unchanged.
  - When full, the push succeeds because a slot frees on the same edge.
- Overflow:
  - Push while full and not popping: the word is dropped and overflow_x is set to 1.
  - overflow_x stays set until reset. The FIFO contents are unaffected.
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH. An extra MSB on each pointer distinguishes full from empty.
- Both lanes valid on the same edge: both are written. Order is still set only by lane_sel.

Decomposition:
- Package mux_unstriping_pkg:
  - LANE0=1'b0 and LANE1=1'b1.
  - PTR_W=$clog2(FIFO_DEPTH).
  - Reset values for data_out and lane_sel.
- Sub-module unstripe_lane_fifo, instantiated twice:
  - Ports: clk_2f, reset, push, din, pop, dout, empty, full, overflow.
  - Synchronous FIFO with a registered count and sticky overflow.
- The top level holds the lane_sel toggle and the output register.

Test Plan:
- Reset, then lane 0 carries 0xA0 at cycle 1 and lane 1 carries 0xB0 at cycle 2 -> data_out shows 0xA0 at cycle 2 and 0xB0 at cycle 3, valid_out=1 in both; lane_sel returns to 0.
- Skew: lane 1 carries 0x11 and 0x22 at cycles 1–2 while lane 0 is idle; lane 0 then carries 0x01 and 0x02 at cycles 5–6 -> output order 0x01, 0x11, 0x02, 0x22, with valid_out=0 through cycle 5.
- Overflow: five lane 1 words 0x1..0x5 with lane 0 idle -> overflow_1=1 after the 5th edge. Then lane 0 carries 0xA, 0xB, 0xC, 0xD -> output A,1,B,2,C,3,D,4; 0x5 never appears.
- Full plus pop: FIFO 0 holds 4 words while being drained, and a new lane 0 word arrives on a pop edge -> no overflow; all words come out in order.
- Mid-stream reset: reset=1 for 1 cycle with 3 words buffered -> valid_out=0 next cycle and the buffered words are lost. Lane 1 word 0x77 then lane 0 word 0x66 after release -> 0x66 output first, then 0x77.
- Back-to-back: a 32-word counter stream is striped alternately across the lanes with no gaps -> 32 consecutive valid_out cycles, and data_out equals the counter sequence.
